button_toggle_debouncer: RTL and testbench
==========================================

// Module: button_toggle_debouncer
// PURPOSE
// - Front end for the LED flasher control input: cleans a raw push-button and
//   emits single-cycle toggle_flash-style pulses on each debounced press/release.
// - Sits between FPGA button pin and flasher FSMs; one instance per button.
// - Debounce by 4-state Moore FSM plus stability counter; optional long-press detect.
// PARAMETERS
// - CLK_FREQ_HZ    50000000  input clock frequency
// - DEBOUNCE_MS    20        required stable time; DEBOUNCE_CYCLES = CLK_FREQ_HZ/1000*DEBOUNCE_MS (must be >= 2)
// - LONG_PRESS_MS  1000      hold time for long press; LONG_CYCLES = CLK_FREQ_HZ/1000*LONG_PRESS_MS (> DEBOUNCE_CYCLES)
// PORTS
// - clk_in            in   1  system clock, all logic on rising edge
// - rst_n_in          in   1  asynchronous, active-low reset
// - btn_in            in   1  raw button, active-high, asynchronous to clk_in
// - btn_level_out     out  1  debounced button level
// - press_pulse_out   out  1  1-cycle pulse on debounced press (drives toggle_flash)
// - release_pulse_out out  1  1-cycle pulse on debounced release
// - long_press_out    out  1  1-cycle pulse once per press after LONG_CYCLES held
// BEHAVIOUR
// - Reset (rst_n_in=0, immediate): all outputs 0, sync flops 0, state IDLE, counters 0.
// - btn_in through 2-flop synchronizer -> s. FSM sees s only.
// - States (registered, Moore outputs registered):
//   IDLE: s=1 -> PRESS_WAIT, cnt<=1; else stay.
//   PRESS_WAIT: s=0 -> IDLE, cnt<=0 (glitch rejected, no pulse);
//     s=1 & cnt==DEBOUNCE_CYCLES-1 -> HELD, press_pulse, btn_level<=1, cnt<=0; else cnt++.
//   HELD: s=0 -> RELEASE_WAIT, cnt<=1; else stay.
//   RELEASE_WAIT: s=1 -> HELD, cnt<=0 (bounce on release rejected);
//     s=0 & cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse, btn_level<=0; else cnt++.
// - Latency: btn_in held 1 -> press_pulse_out high after DEBOUNCE_CYCLES+2 rising edges,
//   counting the first edge sampling btn_in=1; release symmetric.
// - Pulses are exactly 1 cycle; press and release never in same cycle; no two presses
//   without an intervening release.
// - cnt width $clog2(DEBOUNCE_CYCLES+1); never exceeds DEBOUNCE_CYCLES-1.
// - Async reset mid-debounce or mid-hold: abort, no pulse emitted; after release of reset
//   a still-held button goes through full PRESS_WAIT and yields a fresh press_pulse.
// CONFIGURATION
// - Macro BTN_LONG_PRESS_EN.
//   Defined: hold counter (width $clog2(LONG_CYCLES+1)) cleared on entry to HELD,
//   increments in HELD and RELEASE_WAIT, saturates at LONG_CYCLES; long_press_out pulses
//   1 cycle when it reaches LONG_CYCLES-1; max once per press; cleared in IDLE.
//   Undefined: no hold counter; long_press_out tied 0; all else identical.
// STRUCTURE
// - Include file btn_defs.vh: state encodings (IDLE=0, PRESS_WAIT=1, HELD=2,
//   RELEASE_WAIT=3, 2-bit), ms-to-cycles constant expression, shared with flasher FSMs.
// - One sub-module: sync_2ff (1-bit, async active-low reset to 0); rest flat.
// TESTING (bench: CLK_FREQ_HZ=1000, DEBOUNCE_MS=4 -> 4 cycles, LONG_PRESS_MS=20 -> 20 cycles)
// - Clean press held 10 cycles then release -> press_pulse at edge 6, btn_level 1;
//   release_pulse 6 edges after btn_in falls; each pulse exactly 1 cycle.
// - Bounce 1,0,1,0 every cycle then steady 1 -> single press_pulse 6 edges after steady;
//   glitch pulses of 1-3 cycles alone -> no pulse, btn_level stays 0.
// - Release bounce: in HELD, btn_in 0 for 2 cycles then 1 -> no release_pulse, stays HELD.
// - Reset asserted mid PRESS_WAIT and mid HELD -> outputs 0 at once; button still held
//   after reset -> new press_pulse 6 edges after rst_n_in rises.
// - BTN_LONG_PRESS_EN on: hold 30 cycles -> one long_press_out pulse 20 cycles after
//   press_pulse, none after; macro off: long_press_out constantly 0.

Source files
------------

// File: rtl/button_toggle_debouncer_pkg.sv
// Shared definitions for the button debouncer and the flasher FSMs: state
// encodings and the ms-to-cycles conversion used to size the counters.
package button_toggle_debouncer_pkg;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StHeld        = 2'd2,
    StReleaseWait = 2'd3
  } btn_state_e;

  // Divide first so large clock frequencies do not overflow 32 bits.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq_hz,
                                               input int unsigned ms);
    return clk_freq_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/button_toggle_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_toggle_debouncer.sv
// Push-button debouncer emitting 1-cycle press/release pulses and a level.
// Define BTN_LONG_PRESS_EN to add the long-press pulse; otherwise it is tied 0.
module button_toggle_debouncer
  import button_toggle_debouncer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50000000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic btn_in,
  output logic btn_level_out,
  output logic press_pulse_out,
  output logic release_pulse_out,
  output logic long_press_out
);

  localparam int unsigned DebounceCycles = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned LongCycles     = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
  localparam int unsigned CntW           = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast    = CntW'(DebounceCycles - 1);

  if (DebounceCycles < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LongCycles <= DebounceCycles) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic btn_s;

  sync_2ff u_sync (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .d_i    (btn_in),
    .q_o    (btn_s)
  );

  btn_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_s) begin
          state_d = StPressWait;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StPressWait: begin
        if (!btn_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StHeld;
          press_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHeld: begin
        if (!btn_s) begin
          state_d = StReleaseWait;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StReleaseWait: begin
        if (btn_s) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          release_d = 1'b1;
          level_d   = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level_out     = level_q;
  assign press_pulse_out   = press_q;
  assign release_pulse_out = release_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HoldW          = $clog2(LongCycles + 1);
  localparam logic [HoldW-1:0] HoldMax   = HoldW'(LongCycles);
  localparam logic [HoldW-1:0] HoldFire  = HoldW'(LongCycles - 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Counter is 0 on entry to HELD and saturates, so the fire value is seen once per press.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (state_q == StHeld || state_q == StReleaseWait) begin
      hold_d = (hold_q == HoldMax) ? hold_q : hold_q + HoldW'(1);
      long_d = (hold_q == HoldFire);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press_out = long_q;
`else
  assign long_press_out = 1'b0;
`endif

endmodule

// File: tb/tb_button_toggle_debouncer.sv
// Directed self-checking bench for button_toggle_debouncer (4-cycle debounce,
// 20-cycle long press).
module tb_button_toggle_debouncer;

`ifdef BTN_LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic level, press, release_p, long_p;

  int errors = 0;
  int checks = 0;

  button_toggle_debouncer #(
    .CLK_FREQ_HZ   (1000),
    .DEBOUNCE_MS   (4),
    .LONG_PRESS_MS (20)
  ) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .btn_in            (btn),
    .btn_level_out     (level),
    .press_pulse_out   (press),
    .release_pulse_out (release_p),
    .long_press_out    (long_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // From IDLE: drive 1, expect press pulse exactly at edge 6.
  task automatic do_press(input string tag);
    btn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk({tag, "_press_early"}, press, 1'b0);
      chk({tag, "_level_early"}, level, 1'b0);
    end
    tick(1);
    chk({tag, "_press_pulse"}, press, 1'b1);
    chk({tag, "_level_set"}, level, 1'b1);
    chk({tag, "_no_release"}, release_p, 1'b0);
    tick(1);
    chk({tag, "_press_1cyc"}, press, 1'b0);
    chk({tag, "_level_hold"}, level, 1'b1);
    chk({tag, "_long_quiet"}, long_p, 1'b0);
  endtask

  // From HELD: drive 0, expect release pulse exactly at edge 6.
  task automatic do_release(input string tag);
    btn = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk({tag, "_rel_early"}, release_p, 1'b0);
      chk({tag, "_lvl_still1"}, level, 1'b1);
    end
    tick(1);
    chk({tag, "_rel_pulse"}, release_p, 1'b1);
    chk({tag, "_lvl_clear"}, level, 1'b0);
    chk({tag, "_no_press"}, press, 1'b0);
    tick(1);
    chk({tag, "_rel_1cyc"}, release_p, 1'b0);
    chk({tag, "_long_off"}, long_p, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, level, 1'b0);
    chk({tag, "_press"}, press, 1'b0);
    chk({tag, "_release"}, release_p, 1'b0);
    chk({tag, "_long"}, long_p, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(2);
    chk_all_zero("idle");

    // Clean press, ~10 cycles held, then release.
    do_press("clean");
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("clean_held_level", level, 1'b1);
    end
    do_release("clean");
    tick(3);

    // Bounce 1,0,1,0 then steady 1.
    for (int i = 0; i < 4; i++) begin
      btn = (i % 2 == 0);
      tick(1);
      chk("bounce_no_press", press, 1'b0);
    end
    do_press("bounce");
    do_release("bounce");
    tick(3);

    // Short glitches of 1..3 cycles are rejected.
    for (int len = 1; len <= 3; len++) begin
      btn = 1'b1;
      tick(len);
      btn = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick(1);
        chk("glitch_no_press", press, 1'b0);
        chk("glitch_level", level, 1'b0);
      end
    end

    // Release bounce while held.
    do_press("relb");
    btn = 1'b0;
    tick(2);
    btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("relb_no_release", release_p, 1'b0);
      chk("relb_level", level, 1'b1);
    end
    do_release("relb");
    tick(3);

    // Reset in the middle of PRESS_WAIT.
    btn = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_pw_now");
    tick(2);
    chk_all_zero("rst_pw_hold");
    rst_n = 1'b1;
    do_press("rst_pw_again");

    // Reset while HELD, button still down.
    tick(3);
    chk("held_before_rst", level, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_held_now");
    tick(2);
    rst_n = 1'b1;
    do_press("rst_held_again");
    do_release("rst_held_again");
    tick(3);

    // Long hold: one long pulse exactly 20 edges after the press pulse.
    do_press("long");
    for (int k = 2; k <= 30; k++) begin
      tick(1);
      chk("long_pulse", long_p, LongEn && (k == 20));
      chk("long_level", level, 1'b1);
    end
    do_release("long");
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
